// File: rtl/etpu_pkg.sv
// Shared types and constants for the eTPU Wishbone initiator.
package etpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_DATA,
    ST_REQ,
    ST_GAP,
    ST_DONE
  } state_e;

  localparam logic [3:0]  WB_SEL_ALL     = 4'hF;
  localparam logic [31:0] ETPU_BASE_ADDR = 32'h3000_0000;

  // Word-granular beat address; wraps modulo 2^32.
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [7:0] beat);
    return start + {22'd0, beat, 2'b00};
  endfunction

endpackage

// File: rtl/etpu_rd_fifo.sv
// Synchronous read-data FIFO; DEPTH must be a power of two so pointers wrap naturally.
module etpu_rd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  import etpu_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign do_pop  = pop && (cnt_q != '0);
  assign do_push = push && ((cnt_q != DEPTH_C) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

  assign rdata = mem_q[rptr_q];
  assign full  = (cnt_q == DEPTH_C);
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/etpu_wb_master.sv
// Wishbone classic initiator for the eTPU slave: turns burst commands into
// single-beat cycles, fed by a write stream and draining into a read FIFO.
module etpu_wb_master
  import etpu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = ETPU_BASE_ADDR,
  parameter int          FIFO_DEPTH = 8,
  parameter int          TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_e      state_q;
  logic        cmd_ready_q, busy_q, done_q, err_q, wr_ready_q;
  logic        stb_q, we_q, dir_q;
  logic [3:0]  sel_q;
  logic [31:0] adr_q, dat_q, start_q;
  logic [7:0]  len_q, beat_q, beat_d;
  logic [15:0] tmo_q;

  logic          fifo_push, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          space_ok;
  logic          addr_lsb_unused;

  assign addr_lsb_unused = ^cmd_addr[1:0];
  assign beat_d          = beat_q + 8'd1;
  assign space_ok        = (fifo_count < CW'(FIFO_DEPTH));
  assign fifo_push       = (state_q == ST_REQ) && stb_q && wb_ack_i && !dir_q && !fifo_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      wr_ready_q  <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      dir_q       <= 1'b0;
      start_q     <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      tmo_q       <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            dir_q       <= cmd_write;
            start_q     <= BASE_ADDR + {cmd_addr[31:2], 2'b00};
            len_q       <= cmd_len;
            beat_q      <= '0;
            if (cmd_len == 8'd0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else if (cmd_write) begin
              state_q    <= ST_WAIT_DATA;
              wr_ready_q <= 1'b1;
            end else begin
              state_q <= ST_GAP;
            end
          end
        end
        ST_WAIT_DATA: begin
          if (wr_valid) begin
            wr_ready_q <= 1'b0;
            dat_q      <= wr_data;
            state_q    <= ST_REQ;
            stb_q      <= 1'b1;
            sel_q      <= WB_SEL_ALL;
            we_q       <= dir_q;
            adr_q      <= beat_addr(start_q, beat_q);
            tmo_q      <= '0;
          end
        end
        // Reads only strobe once a FIFO slot is guaranteed for the returning word.
        ST_GAP: begin
          if (space_ok) begin
            state_q <= ST_REQ;
            stb_q   <= 1'b1;
            sel_q   <= WB_SEL_ALL;
            we_q    <= dir_q;
            adr_q   <= beat_addr(start_q, beat_q);
            tmo_q   <= '0;
          end
        end
        ST_REQ: begin
          if (wb_ack_i) begin
            stb_q  <= 1'b0;
            sel_q  <= '0;
            we_q   <= 1'b0;
            beat_q <= beat_d;
            if (beat_d == len_q) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else if (dir_q) begin
              state_q    <= ST_WAIT_DATA;
              wr_ready_q <= 1'b1;
            end else begin
              state_q <= ST_GAP;
            end
          end else if (tmo_q == TMO_LAST) begin
            stb_q   <= 1'b0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
        end
        ST_DONE: begin
          state_q     <= ST_IDLE;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  etpu_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_rd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (rd_ready),
    .wdata (wb_dat_i),
    .rdata (rd_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign wr_ready  = wr_ready_q;
  assign rd_valid  = !fifo_empty;
  assign wb_cyc_o  = stb_q;
  assign wb_stb_o  = stb_q;
  assign wb_we_o   = we_q;
  assign wb_sel_o  = sel_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;

endmodule
